// File: rtl/cp_dispatch_unit.sv
// Coprocessor dispatch unit: one CPU request in flight, routed to a
// selected coprocessor channel, with timeout abort and a response hold.
module cp_dispatch_unit #(
  parameter int DATA_WIDTH     = 64,
  parameter int INST_WIDTH     = 32,
  parameter int CP_NUM         = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SW            = $clog2(CP_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [SW-1:0]                req_sel,
  input  logic [INST_WIDTH-1:0]        req_inst,
  input  logic [DATA_WIDTH-1:0]        req_data,
  input  logic [CP_NUM-1:0]            cp_en_mask,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_exc,
  output logic [1:0]                   rsp_cause,
  output logic [CP_NUM-1:0]            cp_req_valid,
  input  logic [CP_NUM-1:0]            cp_req_ready,
  output logic [INST_WIDTH-1:0]        cp_inst,
  output logic [DATA_WIDTH-1:0]        cp_data,
  input  logic [CP_NUM-1:0]            cp_rsp_valid,
  input  logic [CP_NUM*DATA_WIDTH-1:0] cp_rsp_data,
  input  logic [CP_NUM-1:0]            cp_rsp_exc,
  output logic [15:0]                  timeout_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] C_OK  = 2'b00;
  localparam logic [1:0] C_EXC = 2'b01;
  localparam logic [1:0] C_SEL = 2'b10;
  localparam logic [1:0] C_TMO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [SW-1:0]         sel_q, sel_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            cause_q, cause_d;
  logic [15:0]           tcnt_q, tcnt_d;

  logic                  ch_req_rdy;
  logic                  ch_rsp_vld;
  logic                  ch_rsp_exc;
  logic [DATA_WIDTH-1:0] ch_rsp_dat;
  logic                  sel_ok;

  // Selected-channel view; unselected channels are invisible to the FSM
  always_comb begin
    ch_req_rdy = 1'b0;
    ch_rsp_vld = 1'b0;
    ch_rsp_exc = 1'b0;
    ch_rsp_dat = '0;
    sel_ok     = 1'b0;
    for (int i = 0; i < CP_NUM; i++) begin
      if (sel_q == SW'(i)) begin
        ch_req_rdy = cp_req_ready[i];
        ch_rsp_vld = cp_rsp_valid[i];
        ch_rsp_exc = cp_rsp_exc[i];
        ch_rsp_dat = cp_rsp_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (req_sel == SW'(i)) begin
        sel_ok = cp_en_mask[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      inst_q  <= '0;
      data_q  <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      cause_q <= C_OK;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      cause_q <= cause_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    inst_d  = inst_q;
    data_d  = data_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    cause_d = cause_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sel_d  = req_sel;
          inst_d = req_inst;
          data_d = req_data;
          if (sel_ok) begin
            state_d = S_ISSUE;
            timer_d = '0;
          end else begin
            state_d = S_RESP;
            rdata_d = '0;
            cause_d = C_SEL;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A response in the expiry cycle beats the timeout
        if (ch_rsp_vld && (state_q == S_WAIT || ch_req_rdy)) begin
          state_d = S_RESP;
          rdata_d = ch_rsp_dat;
          cause_d = ch_rsp_exc ? C_EXC : C_OK;
        end else if (timer_q == TMAX) begin
          state_d = S_RESP;
          rdata_d = '0;
          cause_d = C_TMO;
          if (tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
          end
        end else if (state_q == S_ISSUE && ch_req_rdy) begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == S_IDLE);
    rsp_valid    = (state_q == S_RESP);
    rsp_exc      = (cause_q != C_OK);
    cp_req_valid = '0;
    for (int i = 0; i < CP_NUM; i++) begin
      cp_req_valid[i] = (state_q == S_ISSUE) && (sel_q == SW'(i));
    end
  end

  assign rsp_data      = rdata_q;
  assign rsp_cause     = cause_q;
  assign cp_inst       = inst_q;
  assign cp_data       = data_q;
  assign timeout_count = tcnt_q;

endmodule

// File: tb/tb_cp_dispatch_unit.sv
// Scoreboard bench for cp_dispatch_unit: expected responses are queued
// at issue time and popped when the unit presents its response.
module tb_cp_dispatch_unit;

  localparam int DW  = 64;
  localparam int IW  = 32;
  localparam int CPN = 4;
  localparam int TO  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_sel;
  logic [IW-1:0]   req_inst;
  logic [DW-1:0]   req_data;
  logic [CPN-1:0]  cp_en_mask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_exc;
  logic [1:0]      rsp_cause;
  logic [CPN-1:0]  cp_req_valid;
  logic [CPN-1:0]  cp_req_ready;
  logic [IW-1:0]   cp_inst;
  logic [DW-1:0]   cp_data;
  logic [CPN-1:0]  cp_rsp_valid;
  logic [CPN*DW-1:0] cp_rsp_data;
  logic [CPN-1:0]  cp_rsp_exc;
  logic [15:0]     timeout_count;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    cause;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp_dispatch_unit #(
    .DATA_WIDTH(DW),
    .INST_WIDTH(IW),
    .CP_NUM(CPN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel(req_sel),
    .req_inst(req_inst),
    .req_data(req_data),
    .cp_en_mask(cp_en_mask),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_exc(rsp_exc),
    .rsp_cause(rsp_cause),
    .cp_req_valid(cp_req_valid),
    .cp_req_ready(cp_req_ready),
    .cp_inst(cp_inst),
    .cp_data(cp_data),
    .cp_rsp_valid(cp_rsp_valid),
    .cp_rsp_data(cp_rsp_data),
    .cp_rsp_exc(cp_rsp_exc),
    .timeout_count(timeout_count)
  );

  task automatic cp_clear();
    cp_req_ready = '0;
    cp_rsp_valid = '0;
    cp_rsp_exc   = '0;
    cp_rsp_data  = '0;
  endtask

  // Called at a negedge with the unit idle; returns one negedge after the handshake
  task automatic send(input logic [1:0] s, input logic [IW-1:0] ins, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_sel   = s;
    req_inst  = ins;
    req_data  = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_exc, rsp_cause, cp_req_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctl: got %b/%b/%b/%b want 0", rsp_valid, rsp_exc, rsp_cause, cp_req_valid);
    end
    checks++;
    if ({rsp_data, cp_inst, cp_data, timeout_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h want 0", rsp_data, cp_inst, cp_data, timeout_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    send(2'd2, 32'hCAFE_0001, 64'h1234);
    checks++;
    if (cp_req_valid !== 4'b0100) begin
      errors++;
      $display("FAIL basic_strobe: got %b want 0100", cp_req_valid);
    end
    checks++;
    if (cp_inst !== 32'hCAFE_0001 || cp_data !== 64'h1234) begin
      errors++;
      $display("FAIL basic_latch: got %h %h want cafe0001 1234", cp_inst, cp_data);
    end
    cp_req_ready[2] = 1'b1;
    cp_rsp_valid[2] = 1'b1;
    cp_rsp_data[2*DW +: DW] = 64'hABCD;
    sb.push_back('{data: 64'hABCD, cause: 2'b00});
    @(negedge clk);
    cp_clear();
    checks++;
    if (rsp_valid !== 1'b1 || sb.size() == 0) begin
      errors++;
      $display("FAIL basic_latency: rsp_valid %b want 1 at N+2", rsp_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rsp_data !== e.data || rsp_cause !== e.cause || rsp_exc !== 1'b0) begin
        errors++;
        $display("FAIL basic_rsp: got %h/%b/%b want %h/%b/0", rsp_data, rsp_cause, rsp_exc, e.data, e.cause);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: req_ready %b rsp_valid %b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_disabled();
    exp_t e;
    cp_en_mask = 4'b1101;
    send(2'd1, 32'h1, 64'h99);
    sb.push_back('{data: '0, cause: 2'b10});
    checks++;
    if (cp_req_valid !== 4'b0000) begin
      errors++;
      $display("FAIL dis_strobe: got %b want 0000", cp_req_valid);
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL dis_valid: got %b want 1", rsp_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rsp_data !== e.data || rsp_cause !== e.cause || rsp_exc !== 1'b1) begin
        errors++;
        $display("FAIL dis_rsp: got %h/%b/%b want %h/%b/1", rsp_data, rsp_cause, rsp_exc, e.data, e.cause);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cp_en_mask = 4'b1111;
  endtask

  task automatic test_timeout();
    exp_t e;
    int cyc = 0;
    send(2'd0, 32'h2, 64'h5);
    sb.push_back('{data: '0, cause: 2'b11});
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      cp_req_ready[0] = (cyc == 1);
      @(negedge clk);
      cyc++;
    end
    cp_clear();
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL tmo_cycles: got %0d want 8", cyc);
    end
    if (rsp_valid === 1'b1) begin
      e = sb.pop_front();
      checks++;
      if (rsp_data !== e.data || rsp_cause !== e.cause || rsp_exc !== 1'b1) begin
        errors++;
        $display("FAIL tmo_rsp: got %h/%b/%b want %h/%b/1", rsp_data, rsp_cause, rsp_exc, e.data, e.cause);
      end
    end else begin
      void'(sb.pop_front());
    end
    checks++;
    if (cp_req_valid !== 4'b0000 || timeout_count !== 16'd1) begin
      errors++;
      $display("FAIL tmo_count: strobe %b count %0d want 0000 1", cp_req_valid, timeout_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_race();
    exp_t e;
    send(2'd0, 32'h3, 64'h6);
    cp_req_ready[0] = 1'b1;
    @(negedge clk);
    cp_req_ready[0] = 1'b0;
    repeat (6) @(negedge clk);
    cp_rsp_valid[0] = 1'b1;
    cp_rsp_data[0 +: DW] = 64'h5A5A;
    sb.push_back('{data: 64'h5A5A, cause: 2'b00});
    @(negedge clk);
    cp_clear();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL race_valid: got %b want 1", rsp_valid);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      checks++;
      if (rsp_data !== e.data || rsp_cause !== e.cause || timeout_count !== 16'd1) begin
        errors++;
        $display("FAIL race_rsp: got %h/%b cnt %0d want %h/%b cnt 1", rsp_data, rsp_cause, timeout_count, e.data, e.cause);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_exc_hold();
    exp_t e;
    send(2'd3, 32'h4, 64'h7);
    cp_req_ready[3] = 1'b1;
    @(negedge clk);
    cp_req_ready[3] = 1'b0;
    cp_rsp_valid[3] = 1'b1;
    cp_rsp_exc[3]   = 1'b1;
    cp_rsp_data[3*DW +: DW] = 64'h55;
    sb.push_back('{data: 64'h55, cause: 2'b01});
    @(negedge clk);
    cp_clear();
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_exc !== 1'b1 || rsp_cause !== e.cause || rsp_data !== e.data) begin
        errors++;
        $display("FAIL hold_%0d: got %b/%b/%b/%h want 1/1/%b/%h", k, rsp_valid, rsp_exc, rsp_cause, rsp_data, e.cause, e.data);
      end
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: req_ready %b rsp_valid %b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_ignore();
    exp_t e;
    send(2'd2, 32'h5, 64'h8);
    cp_req_ready[2] = 1'b1;
    @(negedge clk);
    cp_req_ready[2] = 1'b0;
    cp_rsp_valid[0] = 1'b1;
    cp_rsp_exc[0]   = 1'b1;
    cp_rsp_data[0 +: DW] = 64'hDEAD;
    @(negedge clk);
    cp_clear();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_other: rsp_valid %b want 0", rsp_valid);
    end
    cp_rsp_valid[2] = 1'b1;
    cp_rsp_data[2*DW +: DW] = 64'h7777;
    sb.push_back('{data: 64'h7777, cause: 2'b00});
    @(negedge clk);
    cp_clear();
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_cause !== e.cause) begin
      errors++;
      $display("FAIL ign_rsp: got %b/%h/%b want 1/%h/%b", rsp_valid, rsp_data, rsp_cause, e.data, e.cause);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_mask_change();
    exp_t e;
    send(2'd1, 32'h6, 64'h9);
    cp_en_mask = 4'b0000;
    cp_req_ready[1] = 1'b1;
    cp_rsp_valid[1] = 1'b1;
    cp_rsp_data[1*DW +: DW] = 64'h1111;
    sb.push_back('{data: 64'h1111, cause: 2'b00});
    @(negedge clk);
    cp_clear();
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_cause !== e.cause) begin
      errors++;
      $display("FAIL mask_chg: got %b/%h/%b want 1/%h/%b", rsp_valid, rsp_data, rsp_cause, e.data, e.cause);
    end
    cp_en_mask = 4'b1111;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [1:0]    s;
    logic [DW-1:0] d;
    logic          x;
    for (int k = 0; k < 4; k++) begin
      s = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      x = 1'($urandom_range(0, 1));
      send(s, 32'($urandom), d);
      checks++;
      if (cp_req_valid !== (4'b0001 << s)) begin
        errors++;
        $display("FAIL b2b_strobe_%0d: got %b sel %0d", k, cp_req_valid, s);
      end
      cp_req_ready[s] = 1'b1;
      cp_rsp_valid[s] = 1'b1;
      cp_rsp_exc[s]   = x;
      cp_rsp_data[s*DW +: DW] = d;
      sb.push_back('{data: d, cause: {1'b0, x}});
      @(negedge clk);
      cp_clear();
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_cause !== e.cause || rsp_exc !== x) begin
        errors++;
        $display("FAIL b2b_rsp_%0d: got %b/%h/%b want 1/%h/%b", k, rsp_valid, rsp_data, rsp_cause, e.data, e.cause);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    send(2'd2, 32'h7, 64'hA);
    cp_req_ready[2] = 1'b1;
    @(negedge clk);
    cp_req_ready[2] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || cp_req_valid !== 4'b0000 || cp_inst !== '0 || cp_data !== '0 || timeout_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_async: %b %b %h %h %0d want all 0", rsp_valid, cp_req_valid, cp_inst, cp_data, timeout_count);
    end
    @(negedge clk);
    rst = 1'b0;
    cp_rsp_valid[2] = 1'b1;
    cp_rsp_data[2*DW +: DW] = 64'hBAD;
    @(negedge clk);
    cp_clear();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_quiet_%0d: rsp_valid %b req_ready %b want 0 1", k, rsp_valid, req_ready);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_sel    = '0;
    req_inst   = '0;
    req_data   = '0;
    cp_en_mask = 4'b1111;
    rsp_ready  = 1'b0;
    cp_clear();
    test_reset();
    test_basic();
    test_disabled();
    test_timeout();
    test_race();
    test_exc_hold();
    test_ignore();
    test_mask_change();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
